// File: rtl/exe_mem_stage.sv
// rtl/exe_mem_stage.sv - EXE->MEM pipeline register with store lane pre-decode
// Optional performance counters are enabled with EXE_MEM_PERF_EN.
module exe_mem_stage #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int OP_WIDTH    = 4,
  parameter int STALL_IDX   = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [OP_WIDTH-1:0]    mem_op_i,
  input  logic [5:0]             stall_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_data_o,
  output logic [OP_WIDTH-1:0]    mem_op_o,
  output logic                   mem_we_o,
  output logic [3:0]             mem_be_o,
`ifdef EXE_MEM_PERF_EN
  output logic [CNT_WIDTH-1:0]   bubble_cnt_o,
  output logic [CNT_WIDTH-1:0]   hold_cnt_o,
`endif
  output logic                   misalign_o
);

  localparam logic [OP_WIDTH-1:0] MEM_NOP = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] LB      = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] LH      = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] LW      = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] LBU     = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] LHU     = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] SB      = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] SH      = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] SW      = OP_WIDTH'(8);

  logic hold, bubble, load_en, clear;
  logic is_byte, is_half, is_word, is_load, is_store, misalign;
  logic [1:0] a;
  logic [3:0] be_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic unused_stall;

  assign unused_stall = ^stall_i;
  assign hold    = stall_i[STALL_IDX] & stall_i[STALL_IDX+1];
  assign bubble  = stall_i[STALL_IDX] & ~stall_i[STALL_IDX+1];
  assign load_en = ~stall_i[STALL_IDX];
  // A load slot carrying no real instruction is indistinguishable from a bubble.
  assign clear   = rst_i | flush_i | bubble | (load_en & ~valid_i);

  always_comb begin
    a        = mem_addr_i[1:0];
    is_byte  = (mem_op_i == LB) || (mem_op_i == LBU) || (mem_op_i == SB);
    is_half  = (mem_op_i == LH) || (mem_op_i == LHU) || (mem_op_i == SH);
    is_word  = (mem_op_i == LW) || (mem_op_i == SW);
    is_load  = (mem_op_i == LB) || (mem_op_i == LBU) || (mem_op_i == LH) ||
               (mem_op_i == LHU) || (mem_op_i == LW);
    is_store = (mem_op_i == SB) || (mem_op_i == SH) || (mem_op_i == SW);
    misalign = (is_half && a[0]) || (is_word && (a != 2'b00));
    be_n     = 4'b0000;
    if (!misalign) begin
      if (is_byte)      be_n = 4'b0001 << a;
      else if (is_half) be_n = 4'b0011 << a;
      else if (is_word) be_n = 4'b1111;
    end
    data_n = mem_data_i;
    if (is_byte)      data_n = {(DATA_WIDTH/8){mem_data_i[7:0]}};
    else if (is_half) data_n = {(DATA_WIDTH/16){mem_data_i[15:0]}};
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      valid_o     <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_op_o    <= MEM_NOP;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      misalign_o  <= 1'b0;
    end else if (load_en) begin
      valid_o     <= 1'b1;
      reg_waddr_o <= reg_waddr_i;
      // Misaligned loads trap, so they must never reach the register file.
      reg_we_o    <= reg_we_i & ~(is_load & misalign);
      reg_wdata_o <= reg_wdata_i;
      mem_addr_o  <= mem_addr_i;
      mem_data_o  <= data_n;
      mem_op_o    <= mem_op_i;
      mem_we_o    <= is_store & ~misalign;
      mem_be_o    <= be_n;
      misalign_o  <= misalign;
    end
  end

`ifdef EXE_MEM_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
      hold_cnt_o   <= '0;
    end else begin
      if ((flush_i || bubble) && (bubble_cnt_o != {CNT_WIDTH{1'b1}}))
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      if (hold && !flush_i && (hold_cnt_o != {CNT_WIDTH{1'b1}}))
        hold_cnt_o <= hold_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// tb/tb_exe_mem_stage.sv - directed self-checking bench for exe_mem_stage
module tb_exe_mem_stage;

  localparam logic [3:0] MEM_NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4;
  localparam logic [3:0] LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
  localparam logic [5:0] ST_HOLD = 6'b011111, ST_BUB = 6'b001111, ST_RUN = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        reg_we_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;

  logic        valid_o, reg_we_o, mem_we_o, misalign_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o, mem_addr_o, mem_data_o;
  logic [3:0]  mem_op_o, mem_be_o;
`ifdef EXE_MEM_PERF_EN
  logic [31:0] bubble_cnt_o, hold_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  int exp_hold = 0;
  int exp_bubble = 0;

  exe_mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .valid_o(valid_o), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
    .reg_wdata_o(reg_wdata_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_op_o(mem_op_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
`ifdef EXE_MEM_PERF_EN
    .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o),
`endif
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  wire [112:0] obs = {valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, mem_addr_o,
                      mem_data_o, mem_op_o, mem_we_o, mem_be_o, misalign_o};

  function automatic logic [112:0] pack(input logic v, input logic [4:0] wa, input logic we,
      input logic [31:0] wd, input logic [31:0] ad, input logic [31:0] md,
      input logic [3:0] op, input logic mwe, input logic [3:0] be, input logic mis);
    return {v, wa, we, wd, ad, md, op, mwe, be, mis};
  endfunction

  localparam logic [112:0] ZERO = 113'd0;

  task automatic drive(input logic v, input logic [4:0] wa, input logic we, input logic [31:0] wd,
      input logic [31:0] ad, input logic [31:0] md, input logic [3:0] op);
    valid_i = v; reg_waddr_i = wa; reg_we_i = we; reg_wdata_i = wd;
    mem_addr_i = ad; mem_data_i = md; mem_op_i = op;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1, 5'd4, 1, 32'h1111_2222, 32'h0000_2000, 32'h3333_4444, SW);
    rst_i = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (obs !== ZERO) begin
        bad++; $display("FAIL reset[%0d] got %h want %h", i, obs, ZERO);
      end
    end
    rst_i = 0;
    exp_hold = 0; exp_bubble = 0;
  endtask

  task automatic test_aligned_sh;
    logic [112:0] e;
    drive(1, 5'd2, 0, 32'h0, 32'h0000_1002, 32'h0000_ABCD, SH);
    step();
    e = pack(1, 5'd2, 0, 32'h0, 32'h1002, 32'hABCD_ABCD, SH, 1, 4'b1100, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL aligned_sh got %h want %h", obs, e); end
  endtask

  task automatic test_bytes;
    logic [112:0] e;
    drive(1, 5'd1, 0, 32'h0, 32'h0000_2003, 32'h1234_5678, SB);
    step();
    e = pack(1, 5'd1, 0, 32'h0, 32'h2003, 32'h7878_7878, SB, 1, 4'b1000, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL sb_lane3 got %h want %h", obs, e); end
    drive(1, 5'd6, 1, 32'h0000_00EE, 32'h0000_2001, 32'h0, LBU);
    step();
    e = pack(1, 5'd6, 1, 32'hEE, 32'h2001, 32'h0, LBU, 0, 4'b0010, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL lbu_lane1 got %h want %h", obs, e); end
    drive(1, 5'd8, 0, 32'h0, 32'h0000_2000, 32'h89AB_CDEF, SW);
    step();
    e = pack(1, 5'd8, 0, 32'h0, 32'h2000, 32'h89AB_CDEF, SW, 1, 4'b1111, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL sw_aligned got %h want %h", obs, e); end
  endtask

  task automatic test_misaligned;
    logic [112:0] e;
    drive(1, 5'd5, 1, 32'h0000_0077, 32'h0000_1001, 32'h0, LW);
    step();
    e = pack(1, 5'd5, 0, 32'h77, 32'h1001, 32'h0, LW, 0, 4'b0000, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL mis_lw got %h want %h", obs, e); end
    drive(1, 5'd3, 0, 32'h0, 32'h0000_1003, 32'h0000_BEEF, SH);
    step();
    e = pack(1, 5'd3, 0, 32'h0, 32'h1003, 32'hBEEF_BEEF, SH, 0, 4'b0000, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL mis_sh got %h want %h", obs, e); end
    drive(1, 5'd3, 0, 32'h0, 32'h0000_1002, 32'h0102_0304, SW);
    step();
    e = pack(1, 5'd3, 0, 32'h0, 32'h1002, 32'h0102_0304, SW, 0, 4'b0000, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL mis_sw got %h want %h", obs, e); end
    drive(1, 5'd9, 1, 32'h0000_0042, 32'h0000_1001, 32'h0, LHU);
    step();
    e = pack(1, 5'd9, 0, 32'h42, 32'h1001, 32'h0, LHU, 0, 4'b0000, 1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL mis_lhu got %h want %h", obs, e); end
  endtask

  task automatic test_hold;
    logic [112:0] e, e2;
    drive(1, 5'd7, 0, 32'h0000_0011, 32'h0000_3000, 32'hDEAD_BEEF, SW);
    step();
    e = pack(1, 5'd7, 0, 32'h11, 32'h3000, 32'hDEAD_BEEF, SW, 1, 4'b1111, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL hold_pre got %h want %h", obs, e); end
    stall_i = ST_HOLD;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 10), 1, 32'(i), 32'h0000_3100 + 32'(i), 32'hFFFF_0000, LB);
      step();
      exp_hold++;
      total++;
      if (obs !== e) begin bad++; $display("FAIL hold[%0d] got %h want %h", i, obs, e); end
    end
`ifdef EXE_MEM_PERF_EN
    total++;
    if (hold_cnt_o !== 32'(exp_hold)) begin
      bad++; $display("FAIL hold_cnt got %0d want %0d", hold_cnt_o, exp_hold);
    end
`endif
    stall_i = ST_RUN;
    drive(1, 5'd3, 1, 32'h0000_0005, 32'h0000_3002, 32'h0000_1234, LH);
    step();
    e2 = pack(1, 5'd3, 1, 32'h5, 32'h3002, 32'h1234_1234, LH, 0, 4'b1100, 0);
    total++;
    if (obs !== e2) begin bad++; $display("FAIL hold_release got %h want %h", obs, e2); end
  endtask

  task automatic test_bubble;
    logic [112:0] e;
    stall_i = ST_BUB;
    drive(1, 5'd1, 1, 32'h1, 32'h0000_4000, 32'h5, SW);
    step();
    exp_bubble++;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL bubble got %h want %h", obs, ZERO); end
    stall_i = ST_RUN;
    drive(1, 5'd9, 1, 32'h0000_00AA, 32'h0000_4004, 32'h0000_0055, LW);
    step();
    e = pack(1, 5'd9, 1, 32'hAA, 32'h4004, 32'h55, LW, 0, 4'b1111, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL after_bubble got %h want %h", obs, e); end
`ifdef EXE_MEM_PERF_EN
    total++;
    if (bubble_cnt_o !== 32'(exp_bubble)) begin
      bad++; $display("FAIL bubble_cnt got %0d want %0d", bubble_cnt_o, exp_bubble);
    end
`endif
  endtask

  task automatic test_valid_low;
    drive(0, 5'd2, 1, 32'h9, 32'h0000_4000, 32'h77, SW);
    step();
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL valid_low got %h want %h", obs, ZERO); end
  endtask

  task automatic test_flush_hold;
    logic [112:0] e;
    drive(1, 5'd4, 0, 32'h0, 32'h0000_5000, 32'hCAFE_F00D, SW);
    step();
    e = pack(1, 5'd4, 0, 32'h0, 32'h5000, 32'hCAFE_F00D, SW, 1, 4'b1111, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL flush_pre got %h want %h", obs, e); end
    stall_i = ST_HOLD; flush_i = 1;
    step();
    exp_bubble++;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL flush_hold got %h want %h", obs, ZERO); end
    flush_i = 0;
    step();
    exp_hold++;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL flush_then_hold got %h want %h", obs, ZERO); end
`ifdef EXE_MEM_PERF_EN
    total++;
    if ({bubble_cnt_o, hold_cnt_o} !== {32'(exp_bubble), 32'(exp_hold)}) begin
      bad++; $display("FAIL flush_cnts got %0d/%0d want %0d/%0d",
                      bubble_cnt_o, hold_cnt_o, exp_bubble, exp_hold);
    end
`endif
    stall_i = ST_RUN;
  endtask

  task automatic test_reset_mid_hold;
    logic [112:0] e;
    drive(1, 5'd12, 0, 32'h0, 32'h0000_6001, 32'h0000_00AB, SB);
    step();
    e = pack(1, 5'd12, 0, 32'h0, 32'h6001, 32'hABAB_ABAB, SB, 1, 4'b0010, 0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL rst_hold_pre got %h want %h", obs, e); end
    stall_i = ST_HOLD;
    step();
    total++;
    if (obs !== e) begin bad++; $display("FAIL rst_hold_held got %h want %h", obs, e); end
    rst_i = 1;
    step();
    exp_hold = 0; exp_bubble = 0;
    total++;
    if (obs !== ZERO) begin bad++; $display("FAIL rst_mid_hold got %h want %h", obs, ZERO); end
`ifdef EXE_MEM_PERF_EN
    total++;
    if ({bubble_cnt_o, hold_cnt_o} !== 64'd0) begin
      bad++; $display("FAIL rst_cnts got %0d/%0d want 0/0", bubble_cnt_o, hold_cnt_o);
    end
`endif
    rst_i = 0; stall_i = ST_RUN;
  endtask

  initial begin
    step();
    test_reset();
    test_aligned_sh();
    test_bytes();
    test_misaligned();
    test_hold();
    test_bubble();
    test_valid_low();
    test_flush_hold();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Parametrised EXE→MEM pipeline register, the next generation of the core's execute/memory boundary. It latches register-writeback and memory-access fields from the execute stage. It honours the six-bit pipeline stall vector (hold versus bubble) and a flush request, and carries a valid bit. It also pre-decodes store byte-enables and address-misalignment for the memory stage, so the MEM stage needs no address arithmetic.

## Interface
Parameters:
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory/register data width; byte-enable logic requires 32
- RADDR_WIDTH, 5, register-file address width
- OP_WIDTH, 4, memory-op code width (codes from defines.v: MEM_NOP, LB, LH, LW, LBU, LHU, SB, SH, SW)
- STALL_IDX, 3, bit of stall_i that stalls this stage's producer (EXE); bit STALL_IDX+1 is the consumer (MEM)
- CNT_WIDTH, 32, performance counter width (only with EXE_MEM_PERF_EN)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  EXE result is a real instruction
- reg_waddr_i  in  RADDR_WIDTH  destination register
- reg_we_i  in  1  register write enable
- reg_wdata_i  in  DATA_WIDTH  ALU result / writeback data
- mem_addr_i  in  ADDR_WIDTH  effective address
- mem_data_i  in  DATA_WIDTH  store data, unshifted
- mem_op_i  in  OP_WIDTH  memory operation
- stall_i  in  6  pipeline stall vector {wb,mem,exe,id,if,pc}
- flush_i  in  1  kill instruction in flight (trap/branch redirect)
- valid_o  out  1  registered instruction valid
- reg_waddr_o, reg_we_o, reg_wdata_o  out  as inputs  registered writeback fields
- mem_addr_o  out  ADDR_WIDTH  registered address
- mem_data_o  out  DATA_WIDTH  store data replicated into lane (byte ×4, half ×2)
- mem_op_o  out  OP_WIDTH  registered op
- mem_we_o  out  1  store request (store op, valid, aligned)
- mem_be_o  out  4  byte enables for stores and loads
- misalign_o  out  1  registered misaligned-access exception
- bubble_cnt_o, hold_cnt_o  out  CNT_WIDTH  perf counters (only with EXE_MEM_PERF_EN)

## Operation
Per-edge priority, highest first:
- rst_i: load the reset state.
- flush_i: load the bubble state.
- hold (stall_i[STALL_IDX] & stall_i[STALL_IDX+1]): all outputs keep their value.
- bubble (stall_i[STALL_IDX] & ~stall_i[STALL_IDX+1]): load the bubble state.
- otherwise: load the inputs.

Reset and bubble states are identical:
- valid_o=0, reg_we_o=0, mem_we_o=0, mem_op_o=MEM_NOP, mem_be_o=0, misalign_o=0.
- All address and data outputs are 0.

Load with valid_i=0 is equivalent to a bubble.

Alignment rules, on mem_addr_i[1:0]:
- LH/LHU/SH: misaligned if bit0=1.
- LW/SW: misaligned if [1:0]≠0.
- Byte ops are never misaligned.

Byte enables, with a=mem_addr_i[1:0]:
- Byte ops: 1<<a.
- Half ops: 4'b0011<<a.
- Word ops: 4'b1111.
- NOP: 0.

Misaligned access:
- misalign_o=1, mem_we_o=0, mem_be_o=0.
- reg_we_o is forced 0 for misaligned loads.
- mem_op_o and mem_addr_o are still registered, for trap value reporting.

mem_we_o=1 only for aligned SB/SH/SW with valid_i=1.

## Timing
- Latency is one cycle: inputs sampled at edge N appear at the outputs after edge N.
- There are no combinational paths from inputs to outputs.
- Hold is indefinite. Release of the stall resumes loading on the first edge with the stall condition low.
- Simultaneous flush_i and hold: flush wins and the held instruction is discarded.
- Simultaneous rst_i and anything: reset wins.
- Reset asserted mid-hold clears the stage on that edge.

## Configuration
- EXE_MEM_PERF_EN defined:
  - bubble_cnt_o increments on every edge that loads the bubble state due to stall or flush (not reset).
  - hold_cnt_o increments on every hold edge.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: the counters and both ports are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst_i for 2 cycles with valid inputs driven → all outputs 0, mem_op_o=MEM_NOP, valid_o=0.
- Aligned SH: addr=0x1002, data=0x0000ABCD → next cycle mem_be_o=4'b1100, mem_data_o=0xABCDABCD, mem_we_o=1, misalign_o=0.
- Misaligned LW: addr=0x1001, reg_we_i=1 → misalign_o=1, reg_we_o=0, mem_be_o=0, mem_addr_o=0x1001.
- Hold: stall_i=6'b011111 for 3 cycles with changing inputs → outputs frozen at the pre-stall SW; with PERF, hold_cnt_o=3.
- Bubble: stall_i=6'b001111 for 1 cycle → valid_o=0, mem_we_o=0; the next unstalled input loads normally; with PERF, bubble_cnt_o=1.
- Flush during hold: stall_i=6'b011111 with flush_i=1 → outputs go to the bubble state on that edge and the held store is never issued.
